seg7_scan_display: RTL and testbench
====================================

// Module: seg7_scan_display
// PURPOSE
//  Read-side counterpart of the 16-bit switch-entry register: latches a 16-bit value and
//  shows it as four hex digits on a common-anode, time-multiplexed 7-segment display.
//  Digit 0 shows bits [3:0] and digit 3 shows bits [15:12]. This matches the nibble map used
//  by the entry register's 2-bit nibble select. Sits between the entry register and the
//  board display pins.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles each digit is lit (100 MHz -> 1 kHz/digit); must be >= 2
//  BLINK_DIV    25000000 clk cycles per blink half-period (used only with SEG7_BLINK_EN)
// PORTS
//  clk     in   1   system clock, all state on rising edge
//  reset   in   1   asynchronous, active-high reset
//  value   in   16  value to display (driven by the entry register's x_out)
//  load    in   1   1 = capture value into shadow register at this edge; 0 = hold shadow
//  sel     in   2   nibble currently being edited (blink target; ignored without SEG7_BLINK_EN)
//  an      out  4   digit enables, active-low, one-hot-low while scanning
//  seg     out  7   segments, active-low, {g,f,e,d,c,b,a}
//  dp      out  1   decimal point, active-low, constant 1 (off)
// BEHAVIOUR
//  - Reset (async, immediate): shadow=0, refresh counter=0, digit idx=0, an=4'b1111,
//    seg=7'b1111111, dp=1, blink counter/phase=0.
//  - Shadow: load=1 -> shadow<=value at the edge. Holding load at 1 tracks value with 1 cycle of lag.
//  - Refresh counter runs 0..REFRESH_DIV-1 and wraps. At the wrap edge, idx<=idx+1 mod 4 (3->0).
//  - Outputs are registered every cycle: an<=~(4'b1<<idx), seg<=hex2seg(shadow[4*idx+:4]).
//    Latency: an/seg change 1 cycle after idx or shadow changes. The first non-blank output is
//    on the 2nd edge after reset release, showing digit 0.
//  - Same-edge load and idx change: the new idx and the new shadow are both used at the next edge.
//  - Decode (active-low gfedcba): 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001
//    5=0010010 6=0000010 7=1111000 8=0000000 9=0010000 A=0001000 b=0000011
//    C=1000110 d=0100001 E=0000110 F=0001110.
//  - No blanking between digits. Exactly one an bit is low at any time after the first output cycle.
// CONFIGURATION
//  - `define SEG7_BLINK_EN. The blink counter runs 0..BLINK_DIV-1 and toggles phase at each wrap.
//    When phase=1 and idx==sel, an<=4'b1111 for that cycle, so the edited digit flashes.
//    The sel change takes effect at the next registered update.
//  - Without SEG7_BLINK_EN: no blink counter exists and sel is unused. Display is steady.
// STRUCTURE
//  - Package seg7_pkg: NUM_DIGITS=4, typedef logic[1:0] digit_idx_t, typedef logic[6:0] seg_t,
//    localparam seg_t SEG_BLANK=7'h7F, function hex2seg(logic[3:0]) -> seg_t.
//  - One sub-module, hex_to_seg7: combinational nibble->seg_t decoder wrapping hex2seg.
//    The top holds shadow, counters, idx and output registers.
// TESTING (bench uses REFRESH_DIV=4, BLINK_DIV=16)
//  1. Assert reset -> an=1111, seg=1111111, dp=1 immediately, including a reset applied mid-cycle.
//  2. load=1 with value=16'h1234 for 1 cycle -> an/seg show 1110/0011001 ('4') for 4 cycles,
//     then 1101/0110000 ('3'), then 1011/0100100 ('2'), then 0111/1111001 ('1'), then 1110 again (wrap).
//  3. Hold load=0 and change value to 16'hFFFF -> the display stays 1234. Pulse load -> the next
//     registered seg shows '4'->'F' (0001110) on the current digit with 1-cycle lag.
//  4. value=16'hA0b8 -> the four digits decode as 8/b/0/A. Check every code 0..F once on digit 0.
//  5. Assert reset while idx=2 -> outputs blank at once. After release, the scan restarts at digit 0 (an=1110).
//  6. With SEG7_BLINK_EN and sel=2'b10 -> an bit 2 is never low during phase=1 (cycles 16..31),
//     while the other digits scan normally. Without the macro, sel has no effect.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: shared types, constants and the hex -> 7-segment decode used by
// the scanned display.
//
//   NUM_DIGITS   number of multiplexed digits on the board
//   digit_idx_t  index of the digit currently being driven
//   seg_t        active-low segment vector, bit order {g,f,e,d,c,b,a}
//   SEG_BLANK    all segments off
//   AN_OFF       all digit enables off (active-low)
//   scan_state_t scan start-up state: the first edge after reset only primes
//                the pipeline, and digit output begins on the following edge
//   hex2seg      nibble -> active-low segment pattern (0-9, A, b, C, d, E, F)
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;
  typedef logic [6:0] seg_t;

  localparam seg_t                  SEG_BLANK = 7'h7F;
  localparam logic [NUM_DIGITS-1:0] AN_OFF    = '1;
  localparam logic [NUM_DIGITS-1:0] AN_ONE    = 4'b0001;

  typedef enum logic {
    SCAN_PRIME,
    SCAN_RUN
  } scan_state_t;

  function automatic seg_t hex2seg(input logic [3:0] nib);
    seg_t s;
    s = SEG_BLANK;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      4'hF: s = 7'b0001110;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_display_hex_to_seg7.sv
// hex_to_seg7: purely combinational nibble -> active-low 7-segment decoder.
//
//   nib_i  in   4  hex digit to display
//   seg_o  out  7  active-low segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = hex2seg(nib_i);
  end

endmodule

// File: rtl/seg7_scan_display.sv
// seg7_scan_display: latches a 16-bit value into a shadow register and shows
// it as four hex digits on a common-anode, time-multiplexed 7-segment display.
// Digit 0 shows bits [3:0], digit 3 shows bits [15:12].
//
// Parameters
//   REFRESH_DIV  clk cycles each digit is lit (>= 2)
//   BLINK_DIV    clk cycles per blink half-period (>= 2, blink builds only)
//
// Ports
//   clk    in   1   system clock, rising edge
//   reset  in   1   asynchronous, active-high reset
//   value  in   16  value to display
//   load   in   1   1 = capture value into the shadow register this edge
//   sel    in   2   digit being edited; flashes when blinking is enabled
//   an     out  4   digit enables, active-low, one-hot-low while scanning
//   seg    out  7   segments, active-low, {g,f,e,d,c,b,a}
//   dp     out  1   decimal point, active-low, held off
//
// Build option
//   SEG7_BLINK_EN  when defined, the digit selected by sel is blanked during
//                  every other BLINK_DIV-cycle period. When undefined, sel is
//                  ignored and the display is steady.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           value,
  input  logic                  load,
  input  logic [1:0]            sel,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int unsigned      REF_W    = $clog2(REFRESH_DIV);
  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  scan_state_t           state_q;
  logic [15:0]           shadow_q, shadow_d;
  logic [REF_W-1:0]      ref_cnt_q, ref_cnt_d;
  logic                  ref_wrap;
  digit_idx_t            idx_q, idx_d;
  logic [NUM_DIGITS-1:0] an_q;
  seg_t                  seg_q;
  logic [3:0]            cur_nib;
  seg_t                  cur_seg;
  logic                  blank_digit;

  // Shadow capture and refresh / digit-index advance.
  always_comb begin
    shadow_d  = load ? value : shadow_q;
    ref_wrap  = (ref_cnt_q == REF_LAST);
    ref_cnt_d = ref_wrap ? '0 : ref_cnt_q + 1'b1;
    idx_d     = ref_wrap ? idx_q + 1'b1 : idx_q;
  end

  // Current digit's nibble is taken from the registered shadow and index, so a
  // same-edge load and index step are both reflected on the following edge.
  always_comb begin
    cur_nib = shadow_q[{idx_q, 2'b00} +: 4];
  end

  hex_to_seg7 u_dec (
    .nib_i (cur_nib),
    .seg_o (cur_seg)
  );

`ifdef SEG7_BLINK_EN
  localparam int unsigned      BLK_W    = $clog2(BLINK_DIV);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

  logic [BLK_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             phase_q, phase_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  always_comb begin
    blank_digit = phase_q && (idx_q == sel);
  end
`else
  localparam int unsigned UNUSED_BLINK_DIV = BLINK_DIV;
  logic unused_sel;

  always_comb begin
    unused_sel  = ^sel;
    blank_digit = 1'b0;
  end
`endif

  // Start-up / scan control with registered outputs. The first edge after
  // reset release moves SCAN_PRIME -> SCAN_RUN with outputs still blank; from
  // then on an/seg are reloaded every cycle from the current index and shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= SCAN_PRIME;
      shadow_q  <= '0;
      ref_cnt_q <= '0;
      idx_q     <= '0;
      an_q      <= AN_OFF;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= SCAN_RUN;
      shadow_q  <= shadow_d;
      ref_cnt_q <= ref_cnt_d;
      idx_q     <= idx_d;
      if (state_q == SCAN_RUN) begin
        an_q  <= blank_digit ? AN_OFF : ~(AN_ONE << idx_q);
        seg_q <= cur_seg;
      end
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] value;
  logic        load;
  logic [1:0]  sel;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  always #5 clk = ~clk;

  seg7_scan_display #(
    .REFRESH_DIV (4),
    .BLINK_DIV   (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .value (value),
    .load  (load),
    .sel   (sel),
    .an    (an),
    .seg   (seg),
    .dp    (dp)
  );

  // Active-low gfedcba patterns for 0..F.
  localparam logic [6:0] SEGTAB [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      tag;
  } exp_t;

  exp_t        sb[$];
  exp_t        m_e;
  int unsigned passed = 0;
  int unsigned total  = 0;

  // Expected-value state: edges since reset release and the shadow contents.
  int unsigned n_edges  = 0;
  logic [15:0] m_shadow = '0;

  // Monitor: one comparison per expected entry, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      m_e = sb.pop_front();
      total++;
      if (an === m_e.an && seg === m_e.seg && dp === m_e.dp)
        passed++;
      else
        $display("FAIL %s: got an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                 m_e.tag, an, seg, dp, m_e.an, m_e.seg, m_e.dp);
    end
  end

  function automatic exp_t blank(input string tag);
    exp_t e;
    e.an  = 4'b1111;
    e.seg = 7'b1111111;
    e.dp  = 1'b1;
    e.tag = tag;
    return e;
  endfunction

  // One clock edge: derive the expected output after this edge, then push it.
  task automatic cyc(input string tag);
    exp_t        e;
    int unsigned idx;
    logic [3:0]  nib;
    @(posedge clk);
    if (n_edges == 0) begin
      e = blank(tag);
    end else begin
      idx   = (n_edges / 4) % 4;
      nib   = m_shadow[4*idx +: 4];
      e.an  = ~(4'b0001 << idx);
      e.seg = SEGTAB[nib];
      e.dp  = 1'b1;
      e.tag = tag;
`ifdef SEG7_BLINK_EN
      if (((n_edges / 16) % 2) == 1 && idx == int'(sel))
        e.an = 4'b1111;
`endif
    end
    if (load) m_shadow = value;
    n_edges++;
    #1;
    sb.push_back(e);
  endtask

  // Reset asserted between edges; outputs must be blank before any further edge.
  task automatic do_reset(input string tag);
    @(posedge clk);
    #2;
    reset = 1'b1;
    sb.push_back(blank({tag, "_async"}));
    #1;
    total++;
    if (an === 4'b1111 && seg === 7'b1111111 && dp === 1'b1)
      passed++;
    else
      $display("FAIL %s_immediate: got an=%b seg=%b dp=%b, expected an=1111 seg=1111111 dp=1",
               tag, an, seg, dp);
    @(posedge clk);
    #1;
    sb.push_back(blank({tag, "_held"}));
    total++;
    if (an === 4'b1111 && seg === 7'b1111111)
      passed++;
    else
      $display("FAIL %s_held_direct: got an=%b seg=%b, expected an=1111 seg=1111111",
               tag, an, seg);
    #2;
    reset    = 1'b0;
    n_edges  = 0;
    m_shadow = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned guard;
    reset = 1'b1;
    load  = 1'b0;
    value = '0;
    sel   = 2'b10;

    // Reset state and first-output latency.
    do_reset("reset");

    // 1234: digits 4,3,2,1 then wrap to digit 0.
    load  = 1'b1;
    value = 16'h1234;
    cyc("load1234");
    load = 1'b0;
    repeat (22) cyc("scan1234");

    // Hold: value changes without load are not shown; sel wiggles.
    value = 16'hFFFF;
    for (int i = 0; i < 16; i++) begin
      sel = 2'(i);
      cyc("hold1234");
    end
    sel  = 2'b10;
    load = 1'b1;
    cyc("pulseFFFF");
    load = 1'b0;
    repeat (8) cyc("showFFFF");

    // A0b8 across all digits.
    value = 16'hA0B8;
    load  = 1'b1;
    cyc("loadA0B8");
    load = 1'b0;
    repeat (16) cyc("scanA0B8");

    // Every code on digit 0, tracking value with load held high.
    load = 1'b1;
    for (int i = 0; i < 16; i++) begin
      value = {12'hA0B, 4'(i)};
      repeat (16) cyc("code_d0");
    end
    load = 1'b0;

    // Reset while digit 2 is lit, then restart at digit 0.
    guard = 0;
    while ((((n_edges - 1) / 4) % 4) != 2 && guard < 32) begin
      cyc("seek_d2");
      guard++;
    end
    do_reset("reset_d2");
    load  = 1'b1;
    value = 16'h5C7E;
    cyc("restart");
    load = 1'b0;
    repeat (8) cyc("restart_scan");

    // sel = 2 through both blink phases.
    sel   = 2'b10;
    load  = 1'b1;
    value = 16'h1234;
    cyc("blink_load");
    load = 1'b0;
    repeat (64) cyc("blink_sel2");

    @(negedge clk);
    #1;
    total++;
    if (dp === 1'b1)
      passed++;
    else
      $display("FAIL dp_final: got dp=%b, expected dp=1", dp);
    while (sb.size() > 0) begin
      m_e = sb.pop_front();
      total++;
      $display("FAIL %s: got no sample, expected an=%b seg=%b", m_e.tag, m_e.an, m_e.seg);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
